dlbf_data_csr_seq: RTL
======================

Name: dlbf_data_csr_seq

Overview:
- Bus initiator that drives the BRAM_PORTA-style CSR port of the dlbf data mover from fabric logic, replacing software for autonomous test runs.
- On start: reads and checks the ID register, pulses the mover reset, programs block size / niter / rollover, asserts go, then polls the done-status register until all four masters report done.
- Finishes by clearing go and reports the result code to the requester.

Parameters:
- POLL_GAP, 16, idle cycles between successive status polls (>=1)
- MAX_POLLS, 1024, polls before declaring timeout (>=1)
- CSR_ID, 32'h0123_4567, expected ID at offset 0x00

Ports:
- BRAM_PORTA_clk  in  1  sole clock
- BRAM_PORTA_rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; ignored while busy
- abort  in  1  one-cycle request; ignored while idle
- cfg_block_size  in  12  value written to offset 0x08
- cfg_niter  in  12  value written to offset 0x0C
- cfg_rollover_addr  in  16  value written to offset 0x10
- BRAM_PORTA_addr  out  20  CSR byte address, bit 19 always 1 during access
- BRAM_PORTA_din  out  32  write data
- BRAM_PORTA_en  out  1  access strobe
- BRAM_PORTA_we  out  1  write qualifier
- csr_rddata  in  32  read data from responder, combinational on address
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- err_code  out  2  0 ok, 1 ID mismatch, 2 timeout, 3 aborted; valid with done, held until next start
- last_status  out  4  status[3:0] from most recent poll

Behaviour:
- Reset: addr=0, din=0, en=0, we=0, busy=0, done=0, err_code=0, last_status=0, state IDLE, counters 0. Reset mid-sequence stops all bus activity next cycle; nothing further is written.
- Config inputs are sampled into internal registers on the accepted start; later changes have no effect until the next start.
- Bus access rules:
  - Write: one cycle with en=1, we=1, addr and din valid.
  - Read: one cycle with en=1, we=0, addr valid (strobe cycle). Next cycle en=0 with addr held; csr_rddata is sampled at the end of that cycle.
  - Outside accesses: en=0, we=0, din=0.
- States and transitions (one cycle each unless noted):
  - IDLE: start -> RD_ID; busy=1 from the next cycle.
  - RD_ID: read at 0x80000.
  - CHK_ID: sample. Mismatch -> FIN with err 1, no writes issued. Match -> WR_RST.
  - WR_RST: write 0x80004 <= 0x1.
  - WR_BS: write 0x80008 <= zero-extended block_size.
  - WR_NI: write 0x8000C <= zero-extended niter.
  - WR_RO: write 0x80010 <= zero-extended rollover_addr.
  - WR_GO: write 0x80004 <= 0x10 (go=1, reset released).
  - POLL_RD: read at 0x80020.
  - POLL_CHK: sample, update last_status, increment poll_cnt.
    - status[3:0]==4'hF -> WR_CLR.
    - Else poll_cnt==MAX_POLLS -> WR_ABT with err 2.
    - Else -> POLL_WAIT.
  - POLL_WAIT: POLL_GAP cycles, then -> POLL_RD.
  - WR_CLR: write 0x80004 <= 0x0 -> FIN, err 0.
  - WR_ABT: write 0x80004 <= 0x1 (hold mover in reset) -> FIN.
  - FIN: done=1, busy=0 in this cycle -> IDLE.
- Abort:
  - Sampled in any state except IDLE, WR_ABT, FIN -> next state WR_ABT, err 3.
  - Abort during CHK_ID also goes to WR_ABT, even on ID mismatch.
  - Abort coincident with an all-done poll result or a timeout result wins (err 3).
- start asserted in FIN is ignored. start must be re-asserted after returning to IDLE.
- poll_cnt is 11 bits, sized for MAX_POLLS, and is cleared on start.
- Happy-path latency with an immediate done: start sampled at edge k; done high during cycle k+11 (11 states).

Test Plan:
- ID ok, status=4'hF at first poll, cfg=(384,4,1536) -> writes in order 0x80004=0x1, 0x80008=0x180, 0x8000C=0x4, 0x80010=0x600, 0x80004=0x10, one read of 0x80020, then 0x80004=0x0; done at k+11, err 0, last_status=F.
- csr_rddata returns 0xDEADBEEF at ID read -> no write strobes at all; done at k+3, err 1.
- MAX_POLLS=3, POLL_GAP=2, status stuck at 4'h7 -> exactly 3 polls spaced 3 cycles (strobe, sample, 2 wait, next strobe); final write 0x80004=0x1; err 2, last_status=7.
- Status goes 0x0, 0x5, then 0xF -> 3 polls, then clear write; err 0; start pulsed while busy has no effect.
- abort during POLL_WAIT -> next cycle write 0x80004=0x1, then done with err 3; abort in IDLE -> no activity.
- BRAM_PORTA_rst asserted in WR_NI -> en=0 next cycle, busy=0, done never pulses; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/dlbf_data_csr_seq.sv
// Autonomous CSR initiator for the dlbf data mover: checks the ID register, programs
// and starts the mover, polls until all four masters are done, then reports a result code.
module dlbf_data_csr_seq #(
    parameter int unsigned POLL_GAP  = 16,
    parameter int unsigned MAX_POLLS = 1024,
    parameter logic [31:0] CSR_ID    = 32'h0123_4567
) (
    input  logic        BRAM_PORTA_clk,
    input  logic        BRAM_PORTA_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] cfg_block_size,
    input  logic [11:0] cfg_niter,
    input  logic [15:0] cfg_rollover_addr,
    output logic [19:0] BRAM_PORTA_addr,
    output logic [31:0] BRAM_PORTA_din,
    output logic        BRAM_PORTA_en,
    output logic        BRAM_PORTA_we,
    input  logic [31:0] csr_rddata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [3:0]  last_status
);

    localparam logic [19:0] ADDR_ID   = 20'h80000;
    localparam logic [19:0] ADDR_CTRL = 20'h80004;
    localparam logic [19:0] ADDR_BS   = 20'h80008;
    localparam logic [19:0] ADDR_NI   = 20'h8000C;
    localparam logic [19:0] ADDR_RO   = 20'h80010;
    localparam logic [19:0] ADDR_STAT = 20'h80020;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    localparam int unsigned PCNT_W = 11;
    localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_ID, S_CHK_ID, S_WR_RST, S_WR_BS, S_WR_NI, S_WR_RO, S_WR_GO,
        S_POLL_RD, S_POLL_CHK, S_POLL_WAIT, S_WR_CLR, S_WR_ABT, S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          err_q, err_d;
    logic [PCNT_W-1:0]   poll_q, poll_d, poll_inc;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [3:0]          stat_q, stat_d;
    logic [11:0]         bs_q, bs_d, ni_q, ni_d;
    logic [15:0]         ro_q, ro_d;
    logic [19:0]         addr_q;
    logic [31:0]         din_q;
    logic                en_q, we_q, busy_q, done_q;

    assign BRAM_PORTA_addr = addr_q;
    assign BRAM_PORTA_din  = din_q;
    assign BRAM_PORTA_en   = en_q;
    assign BRAM_PORTA_we   = we_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_code        = err_q;
    assign last_status     = stat_q;

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
        stat_d   = stat_q;
        bs_d     = bs_q;
        ni_d     = ni_q;
        ro_d     = ro_q;
        poll_inc = poll_q + PCNT_W'(1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_ID;
                    err_d   = ERR_OK;
                    poll_d  = '0;
                    bs_d    = cfg_block_size;
                    ni_d    = cfg_niter;
                    ro_d    = cfg_rollover_addr;
                end
            end
            S_RD_ID:  state_d = S_CHK_ID;
            S_CHK_ID: begin
                if (csr_rddata != CSR_ID) begin
                    state_d = S_FIN;
                    err_d   = ERR_ID;
                end else begin
                    state_d = S_WR_RST;
                end
            end
            S_WR_RST:  state_d = S_WR_BS;
            S_WR_BS:   state_d = S_WR_NI;
            S_WR_NI:   state_d = S_WR_RO;
            S_WR_RO:   state_d = S_WR_GO;
            S_WR_GO:   state_d = S_POLL_RD;
            S_POLL_RD: state_d = S_POLL_CHK;
            S_POLL_CHK: begin
                stat_d = csr_rddata[3:0];
                poll_d = poll_inc;
                if (csr_rddata[3:0] == 4'hF) begin
                    state_d = S_WR_CLR;
                end else if (poll_inc == PCNT_W'(MAX_POLLS)) begin
                    state_d = S_WR_ABT;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d = S_POLL_WAIT;
                    gap_d   = '0;
                end
            end
            S_POLL_WAIT: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_WR_CLR: begin
                state_d = S_FIN;
                err_d   = ERR_OK;
            end
            S_WR_ABT: state_d = S_FIN;
            S_FIN:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort overrides every other outcome, including ID mismatch and poll results.
        if (abort && (state_q != S_IDLE) && (state_q != S_WR_ABT) && (state_q != S_FIN)) begin
            state_d = S_WR_ABT;
            err_d   = ERR_ABORT;
        end
    end

    // Bus outputs are decoded from the next state so they are valid in the state's own cycle.
    always_ff @(posedge BRAM_PORTA_clk) begin
        if (BRAM_PORTA_rst) begin
            state_q <= S_IDLE;
            err_q   <= ERR_OK;
            poll_q  <= '0;
            gap_q   <= '0;
            stat_q  <= '0;
            bs_q    <= '0;
            ni_q    <= '0;
            ro_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
            stat_q  <= stat_d;
            bs_q    <= bs_d;
            ni_q    <= ni_d;
            ro_q    <= ro_d;
            busy_q  <= (state_d != S_IDLE) && (state_d != S_FIN);
            done_q  <= (state_d == S_FIN);
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            din_q   <= '0;
            case (state_d)
                S_RD_ID: begin
                    en_q   <= 1'b1;
                    addr_q <= ADDR_ID;
                end
                S_POLL_RD: begin
                    en_q   <= 1'b1;
                    addr_q <= ADDR_STAT;
                end
                S_WR_RST, S_WR_ABT: begin
                    en_q   <= 1'b1;
                    we_q   <= 1'b1;
                    addr_q <= ADDR_CTRL;
                    din_q  <= 32'h0000_0001;
                end
                S_WR_BS: begin
                    en_q   <= 1'b1;
                    we_q   <= 1'b1;
                    addr_q <= ADDR_BS;
                    din_q  <= {20'h0, bs_q};
                end
                S_WR_NI: begin
                    en_q   <= 1'b1;
                    we_q   <= 1'b1;
                    addr_q <= ADDR_NI;
                    din_q  <= {20'h0, ni_q};
                end
                S_WR_RO: begin
                    en_q   <= 1'b1;
                    we_q   <= 1'b1;
                    addr_q <= ADDR_RO;
                    din_q  <= {16'h0, ro_q};
                end
                S_WR_GO: begin
                    en_q   <= 1'b1;
                    we_q   <= 1'b1;
                    addr_q <= ADDR_CTRL;
                    din_q  <= 32'h0000_0010;
                end
                S_WR_CLR: begin
                    en_q   <= 1'b1;
                    we_q   <= 1'b1;
                    addr_q <= ADDR_CTRL;
                end
                default: ;
            endcase
        end
    end

endmodule
